// File: rtl/fq_scan_ctrl_if.sv
// Control and result bus of the frequency scan controller.
// The consumer side drives the scan requests; the controller answers with status and results.
interface fq_scan_ctrl_if #(
    parameter int N_CH = 4
);
    logic            start;
    logic [N_CH-1:0] ch_mask;
    logic            continuous;
    logic            stop;
    logic            busy;
    logic            result_valid;
    logic [3:0]      result_ch;
    logic [31:0]     measured_freq;
    logic [3:0]      rd_ch;
    logic [31:0]     rd_freq;

    modport master (
        output start, ch_mask, continuous, stop, rd_ch,
        input  busy, result_valid, result_ch, measured_freq, rd_freq
    );

    modport slave (
        input  start, ch_mask, continuous, stop, rd_ch,
        output busy, result_valid, result_ch, measured_freq, rd_freq
    );
endinterface

// File: rtl/fq_scan_ctrl.sv
// Round-robin frequency meter: one gated rising-edge counter is time-shared across the
// enabled channels, each channel settling, gating and storing its count in turn.
module fq_scan_ctrl #(
    parameter int N_CH          = 4,
    parameter int GATE_CYCLES   = 1000000,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic            ref_freq,
    input  logic            nReset,
    input  logic [N_CH-1:0] input_freq,
    fq_scan_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, STORE} state_t;

    localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      cur_ch, ch_d;
    logic [N_CH-1:0] mask_q, mask_d;
    logic            cont_q, cont_d;
    logic            presenting;

    logic [N_CH-1:0] sync1, sync2;
    logic            sel_bit, prev;
    logic [31:0]     count_q;
    logic [31:0]     held_freq;
    logic [3:0]      held_ch;
    logic [31:0]     result_q [N_CH];

    logic [15:0]     start_pad, mask_pad;
    logic [3:0]      start_first, wrap_first, next_ch;
    logic            start_found, next_found;

    always_ff @(posedge ref_freq or negedge nReset) begin
        if (!nReset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= 1'b0;
        end else begin
            sync1 <= input_freq;
            sync2 <= sync1;
            prev  <= sel_bit;
        end
    end

    always_comb begin
        sel_bit = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (cur_ch == 4'(i)) sel_bit = sync2[i];
        end
    end

    // Lowest set bit of the incoming and latched masks, and the next set bit above the current channel.
    always_comb begin
        start_pad   = 16'(bus.ch_mask);
        mask_pad    = 16'(mask_q);
        start_first = 4'd0;
        start_found = 1'b0;
        wrap_first  = 4'd0;
        next_ch     = 4'd0;
        next_found  = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (start_pad[i]) begin
                start_first = 4'(i);
                start_found = 1'b1;
            end
            if (mask_pad[i]) wrap_first = 4'(i);
            if (mask_pad[i] && (i > int'(cur_ch))) begin
                next_ch    = 4'(i);
                next_found = 1'b1;
            end
        end
    end

    always_ff @(posedge ref_freq or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            timer_q <= '0;
            cur_ch  <= 4'd0;
            mask_q  <= '0;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cur_ch  <= ch_d;
            mask_q  <= mask_d;
            cont_q  <= cont_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        ch_d       = cur_ch;
        mask_d     = mask_q;
        cont_d     = cont_q;
        presenting = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && start_found) begin
                    mask_d  = bus.ch_mask;
                    cont_d  = bus.continuous;
                    ch_d    = start_first;
                    timer_d = TW'(SETTLE_CYCLES - 1);
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (timer_q == '0) begin
                    timer_d = TW'(GATE_CYCLES - 1);
                    state_d = GATE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            GATE: begin
                if (timer_q == '0) begin
                    state_d = STORE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            STORE: begin
                presenting = 1'b1;
                timer_d    = TW'(SETTLE_CYCLES - 1);
                if (next_found) begin
                    ch_d    = next_ch;
                    state_d = SETTLE;
                end else if (cont_q) begin
                    ch_d    = wrap_first;
                    state_d = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // An abort outside IDLE wins over everything, including a result about to be published.
        if ((state_q != IDLE) && bus.stop) begin
            state_d    = IDLE;
            presenting = 1'b0;
        end
    end

    always_ff @(posedge ref_freq or negedge nReset) begin
        if (!nReset) begin
            count_q <= '0;
        end else if (state_q == SETTLE) begin
            count_q <= '0;
        end else if ((state_q == GATE) && sel_bit && !prev && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    always_ff @(posedge ref_freq or negedge nReset) begin
        if (!nReset) begin
            held_freq <= '0;
            held_ch   <= 4'd0;
            for (int i = 0; i < N_CH; i++) result_q[i] <= '0;
        end else if (presenting) begin
            held_freq <= count_q;
            held_ch   <= cur_ch;
            for (int i = 0; i < N_CH; i++) begin
                if (cur_ch == 4'(i)) result_q[i] <= count_q;
            end
        end
    end

    always_comb begin
        bus.rd_freq = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.rd_ch == 4'(i)) bus.rd_freq = result_q[i];
        end
    end

    assign bus.busy          = (state_q != IDLE);
    assign bus.result_valid  = presenting;
    assign bus.measured_freq = presenting ? count_q : held_freq;
    assign bus.result_ch     = presenting ? cur_ch : held_ch;

endmodule

// File: tb/tb_fq_scan_ctrl.sv
// Directed scoreboard bench for fq_scan_ctrl: expected strobes are queued at stimulus time
// and a monitor pops them whenever the controller publishes a result.
module tb_fq_scan_ctrl;

    localparam int N_CH = 4;
    localparam int GATE = 100;
    localparam int SETL = 4;
    localparam int PER_CH = SETL + GATE + 1;

    typedef struct {
        logic [3:0]  ch;
        logic [31:0] freq;
        int          cyc;
    } exp_t;

    logic            ref_freq = 1'b0;
    logic            nReset   = 1'b0;
    logic [N_CH-1:0] input_freq = '0;
    int              period [N_CH];
    int              cyc   = 0;
    int              total = 0;
    int              bad   = 0;
    exp_t            sb [$];

    fq_scan_ctrl_if #(.N_CH(N_CH)) bus ();

    fq_scan_ctrl #(
        .N_CH(N_CH),
        .GATE_CYCLES(GATE),
        .SETTLE_CYCLES(SETL)
    ) dut (
        .ref_freq(ref_freq),
        .nReset(nReset),
        .input_freq(input_freq),
        .bus(bus)
    );

    always #5 ref_freq = ~ref_freq;

    always @(posedge ref_freq) cyc <= cyc + 1;

    // Period 0 holds a channel low, a negative period holds it high.
    always @(negedge ref_freq) begin
        for (int c = 0; c < N_CH; c++) begin
            if (period[c] < 0)       input_freq[c] = 1'b1;
            else if (period[c] == 0) input_freq[c] = 1'b0;
            else                     input_freq[c] = ((cyc % period[c]) < (period[c] / 2));
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge ref_freq) begin
        if (nReset && bus.result_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_strobe", 32'(bus.result_ch), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("strobe_ch", 32'(bus.result_ch), 32'(e.ch));
                checkOutput("strobe_freq", bus.measured_freq, e.freq);
                checkOutput("strobe_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic applyStimulus(input logic [N_CH-1:0] mask, input logic cont, output int t0);
        @(negedge ref_freq);
        bus.ch_mask    = mask;
        bus.continuous = cont;
        bus.start      = 1'b1;
        t0             = cyc;
        @(negedge ref_freq);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int fall);
        fall = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge ref_freq);
            if (!bus.busy) begin
                fall = cyc;
                break;
            end
        end
        if (fall < 0) checkOutput("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge ref_freq);
    endtask

    task automatic check_read(input string name, input int ch, input logic [31:0] exp);
        bus.rd_ch = 4'(ch);
        #1;
        checkOutput(name, bus.rd_freq, exp);
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, "_valid"}, 32'(bus.result_valid), 32'd0);
        checkOutput({tag, "_rch"}, 32'(bus.result_ch), 32'd0);
        checkOutput({tag, "_mfreq"}, bus.measured_freq, 32'd0);
        for (int c = 0; c < N_CH; c++) check_read({tag, "_rd"}, c, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation stuck at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int fall;
        for (int c = 0; c < N_CH; c++) period[c] = 0;
        bus.start      = 1'b0;
        bus.ch_mask    = '0;
        bus.continuous = 1'b0;
        bus.stop       = 1'b0;
        bus.rd_ch      = 4'd0;

        // Reset state and a zero-mask start that must be ignored
        repeat (3) @(negedge ref_freq);
        check_all_zero("reset");
        nReset = 1'b1;
        applyStimulus(4'b0000, 1'b0, t0);
        repeat (3) @(negedge ref_freq);
        check_all_zero("zero_mask");

        // Single non-continuous scan over ch0 and ch2
        period[0] = 10;
        period[2] = 25;
        applyStimulus(4'b0101, 1'b0, t0);
        sb.push_back('{ch: 4'd0, freq: 32'd10, cyc: t0 + PER_CH});
        sb.push_back('{ch: 4'd2, freq: 32'd4, cyc: t0 + 2 * PER_CH});
        checkOutput("busy_after_start", 32'(bus.busy), 32'd1);
        wait_idle(400, fall);
        checkOutput("busy_fall", 32'(fall), 32'(t0 + 2 * PER_CH + 1));
        check_read("rd_ch2", 2, 32'd4);
        check_read("rd_ch0", 0, 32'd10);

        // Continuous single-channel wrap, stopped during the fourth gate
        period[3] = 50;
        applyStimulus(4'b1000, 1'b1, t0);
        for (int k = 1; k <= 3; k++) sb.push_back('{ch: 4'd3, freq: 32'd2, cyc: t0 + k * PER_CH});
        wait_until(t0 + 3 * PER_CH + SETL + 5);
        bus.stop = 1'b1;
        @(negedge ref_freq);
        bus.stop = 1'b0;
        checkOutput("cont_stopped", 32'(bus.busy), 32'd0);
        check_read("rd_ch3", 3, 32'd2);

        // Mid-gate abort leaves every stored value untouched
        period[1] = 10;
        applyStimulus(4'b0010, 1'b0, t0);
        wait_until(t0 + SETL + 50);
        checkOutput("busy_mid_gate", 32'(bus.busy), 32'd1);
        bus.stop = 1'b1;
        @(negedge ref_freq);
        bus.stop = 1'b0;
        checkOutput("stop_idle", 32'(bus.busy), 32'd0);
        repeat (60) @(negedge ref_freq);
        check_read("stop_rd_ch1", 1, 32'd0);
        check_read("stop_rd_ch0", 0, 32'd10);
        checkOutput("stop_held_freq", bus.measured_freq, 32'd2);
        checkOutput("stop_held_ch", 32'(bus.result_ch), 32'd3);

        // Static channel with mask/continuous changed after start
        period[1] = -1;
        repeat (5) @(negedge ref_freq);
        applyStimulus(4'b0110, 1'b0, t0);
        bus.ch_mask    = 4'b1001;
        bus.continuous = 1'b1;
        sb.push_back('{ch: 4'd1, freq: 32'd0, cyc: t0 + PER_CH});
        sb.push_back('{ch: 4'd2, freq: 32'd4, cyc: t0 + 2 * PER_CH});
        wait_idle(400, fall);
        checkOutput("latched_busy_fall", 32'(fall), 32'(t0 + 2 * PER_CH + 1));
        check_read("static_rd_ch1", 1, 32'd0);

        // Asynchronous reset in the middle of a gate, then a fresh scan
        applyStimulus(4'b0001, 1'b0, t0);
        wait_until(t0 + SETL + 40);
        nReset = 1'b0;
        #1;
        check_all_zero("async_reset");
        repeat (2) @(negedge ref_freq);
        nReset = 1'b1;
        applyStimulus(4'b0001, 1'b0, t0);
        sb.push_back('{ch: 4'd0, freq: 32'd10, cyc: t0 + PER_CH});
        wait_idle(300, fall);
        checkOutput("fresh_busy_fall", 32'(fall), 32'(t0 + PER_CH + 1));
        check_read("fresh_rd_ch0", 0, 32'd10);
        check_read("fresh_rd_ch2", 2, 32'd0);

        repeat (5) @(negedge ref_freq);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fq_scan_ctrl.md
# fq_scan_ctrl

Multi-channel frequency measurement scheduler that shares one gate-window edge counter among up to N_CH asynchronous input signals. Each enabled channel is measured in turn over a fixed gate of reference-clock cycles, and the resulting edge count is published with a one-cycle valid strobe. The count is also held in a per-channel result register. The block sits between the raw frequency inputs and the system that consumes `measured_freq`-style 32-bit results.

## Interface
- `N_CH`, default 4: number of input channels (1–16).
- `GATE_CYCLES`, default 1000000: gate length in `ref_freq` cycles. The value 1000000 at a 1 MHz reference gives results in Hz.
- `SETTLE_CYCLES`, default 4: flush cycles after each channel switch (≥3).
- `ref_freq`  in  1  sole clock, rising edge.
- `nReset`  in  1  asynchronous, active-low reset.
- `input_freq`  in  N_CH  asynchronous signals under measurement.
- `ch_mask`  in  N_CH  channel enables, sampled on `start`.
- `start`  in  1  one-cycle request to begin a scan; honoured only in IDLE.
- `continuous`  in  1  sampled on `start`. When 1, the scan wraps indefinitely.
- `stop`  in  1  abort request.
- `busy`  out  1  high whenever the state is not IDLE.
- `result_valid`  out  1  one-cycle strobe indicating a new result.
- `result_ch`  out  4  channel index of the current result.
- `measured_freq`  out  32  rising-edge count over the gate for `result_ch`.
- `rd_ch`  in  4  read-port channel select.
- `rd_freq`  out  32  combinational read of the stored result for `rd_ch`. Reads 0 when `rd_ch` ≥ N_CH.

## Operation
- Every channel passes through a 2-flop synchronizer. The synchronized bit of the selected channel is muxed to a single edge detector (`prev` register). An edge is counted when `sync & ~prev`.
- State machine:
  - **IDLE**: on `start` with a nonzero `ch_mask`, latch the mask and `continuous`, select the lowest set bit, and go to SETTLE. A `start` with a zero mask is ignored.
  - **SETTLE**: runs for `SETTLE_CYCLES` cycles. The edge detector tracks the new channel but nothing is counted. The counter is cleared to 0. Then go to GATE.
  - **GATE**: runs for exactly `GATE_CYCLES` cycles, counting edges. The counter saturates at 32'hFFFFFFFF. Then go to STORE.
  - **STORE**: runs for 1 cycle.
    - Load `measured_freq`, `result_ch` and the channel's result register. Pulse `result_valid`.
    - Next channel is the next higher set bit in the latched mask, then go to SETTLE.
    - If no higher bit is set: when `continuous` is set, wrap to the lowest set bit and go to SETTLE; otherwise go to IDLE.
- `stop` is sampled every cycle. If `stop` is seen in SETTLE, GATE or STORE, the next state is IDLE.
  - No result is produced, including when `stop` arrives in STORE; `stop` overrides.
  - Stored registers keep their prior values.
- `ch_mask` and `continuous` changes after `start` have no effect until the next `start`.
- A single-channel mask with `continuous` set re-measures that channel back-to-back, with SETTLE between each measurement.
- Inputs above `ref_freq`/2 alias. This is not detected and is the user's responsibility.

## Timing
- Reset values:
  - IDLE state.
  - `busy`=0, `result_valid`=0, `result_ch`=0, `measured_freq`=0.
  - All result registers, `rd_freq`, counter, synchronizers and `prev` cleared to 0.
- Reset asserted mid-scan returns the block to IDLE immediately and asynchronously, with all values as above.
- If `start` is high in cycle T, `busy`=1 from T+1.
- Per channel, SETTLE+GATE+STORE takes `SETTLE_CYCLES`+`GATE_CYCLES`+1 cycles.
- `result_valid` is high for exactly 1 cycle per result. `measured_freq` and `result_ch` are held until the next STORE.
- In a non-continuous scan, `busy` falls in the cycle after the last STORE.
- From input pin to counted edge is 3 cycles: synchronizer plus detector. Input edges that arrive near gate boundaries may shift the count by ±1 against the ideal value. This is accepted.
- `stop` with `start` in the same cycle while in IDLE: `start` wins.
- The result register is written in the same cycle as `result_valid`. `rd_freq` reflects the new value from the next cycle.

## Test plan
Parameters for all scenarios: N_CH=4, GATE_CYCLES=100, SETTLE_CYCLES=4.
1. Reset check: apply reset, release it, then drive `start` with `ch_mask`=0 → `busy` stays 0, all outputs 0, no `result_valid`.
2. Single scan: ch0 period 10 cycles, ch2 period 25, `ch_mask`=4'b0101, `continuous`=0 → two strobes.
   - Strobe 1: `result_ch`=0, `measured_freq`=10, 105 cycles after `start`.
   - Strobe 2: `result_ch`=2, `measured_freq`=4, 105 cycles later.
   - `busy` falls 1 cycle after strobe 2.
   - `rd_ch`=2 reads 4.
3. Continuous wrap: `ch_mask`=4'b1000, ch3 period 50, `continuous`=1 → `result_valid` every 105 cycles with `measured_freq`=2, repeating ≥3 times.
4. Mid-gate stop: `stop` at cycle 50 of GATE → IDLE next cycle, no strobe, result registers unchanged.
5. Static and mask-change: ch1 held constant; `ch_mask` changed after `start` → result 0 for ch1; the scan order follows the latched mask.
6. Reset during GATE: assert `nReset` mid-gate → outputs and all result registers read 0 immediately; a fresh `start` works normally.
